// File: rtl/iq_nsum.sv
// Block I/Q summer: accumulates 2^n_sel strobed sample pairs, scales by a post-sum shift, saturates.
// Optional: define IQ_NSUM_ROUND_EN for round-half-up before the shift (default: truncation).
module iq_nsum #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_NMAX  = 4,
    parameter int GAIN_LOG2  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ce,
    input  logic                                 strobe_in,
    input  logic                                 sync_clr,
    input  logic [$clog2(LOG2_NMAX+1)-1:0]       n_sel,
    input  logic signed [DATA_WIDTH-1:0]         I_in,
    input  logic signed [DATA_WIDTH-1:0]         Q_in,
    output logic signed [DATA_WIDTH-1:0]         I_sum,
    output logic signed [DATA_WIDTH-1:0]         Q_sum,
    output logic                                 strobe_out,
    output logic                                 sat
);

    localparam int NSEL_W = $clog2(LOG2_NMAX + 1);
    localparam int ACC_W  = DATA_WIDTH + LOG2_NMAX;
    localparam int CNT_W  = LOG2_NMAX + 1;
    localparam int EXT_W  = ACC_W + 1;

    localparam logic signed [EXT_W-1:0] MAX_V = {{(LOG2_NMAX+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(LOG2_NMAX+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    typedef struct packed {
        logic                         flag;
        logic signed [DATA_WIDTH-1:0] val;
    } sat_t;

    state_t                  state, state_n;
    logic signed [ACC_W-1:0] acc_i, acc_q, acc_i_n, acc_q_n, acc_i_sum, acc_q_sum;
    logic [CNT_W-1:0]        count, count_n, cnt_sum;
    logic [NSEL_W-1:0]       n_act, n_act_n, n_clamp, n_use, shift;
    logic signed [DATA_WIDTH-1:0] i_sum_n, q_sum_n;
    logic                    strobe_n, sat_n, accept, first, done;
    sat_t                    res_i, res_q;

    // One extra bit of headroom keeps the rounding add from wrapping before the clamp.
    function automatic sat_t scale(input logic signed [ACC_W-1:0] total,
                                   input logic [NSEL_W-1:0]       sh);
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] shifted;
        sat_t                    r;
        ext = {total[ACC_W-1], total};
`ifdef IQ_NSUM_ROUND_EN
        if (sh != '0)
            ext = ext + (EXT_W'(1) << (sh - NSEL_W'(1)));
`endif
        shifted = ext >>> sh;
        r.flag  = 1'b1;
        if (shifted > MAX_V)
            r.val = MAX_V[DATA_WIDTH-1:0];
        else if (shifted < MIN_V)
            r.val = MIN_V[DATA_WIDTH-1:0];
        else begin
            r.val  = shifted[DATA_WIDTH-1:0];
            r.flag = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_n  = state;
        acc_i_n  = acc_i;
        acc_q_n  = acc_q;
        count_n  = count;
        n_act_n  = n_act;
        i_sum_n  = I_sum;
        q_sum_n  = Q_sum;
        sat_n    = sat;
        strobe_n = 1'b0;

        accept  = ce && strobe_in;
        // A sync_clr arriving with a sample makes that sample the head of a fresh block.
        first   = accept && (state == IDLE || sync_clr);
        n_clamp = (n_sel > NSEL_W'(LOG2_NMAX)) ? NSEL_W'(LOG2_NMAX) : n_sel;
        n_use   = first ? n_clamp : n_act;
        shift   = (n_use > NSEL_W'(GAIN_LOG2)) ? n_use - NSEL_W'(GAIN_LOG2) : '0;

        acc_i_sum = (first ? {ACC_W{1'b0}} : acc_i) + {{LOG2_NMAX{I_in[DATA_WIDTH-1]}}, I_in};
        acc_q_sum = (first ? {ACC_W{1'b0}} : acc_q) + {{LOG2_NMAX{Q_in[DATA_WIDTH-1]}}, Q_in};
        cnt_sum   = (first ? {CNT_W{1'b0}} : count) + CNT_W'(1);
        done      = accept && (cnt_sum == (CNT_W'(1) << n_use));

        res_i = scale(acc_i_sum, shift);
        res_q = scale(acc_q_sum, shift);

        if (ce) begin
            if (accept) begin
                acc_i_n = acc_i_sum;
                acc_q_n = acc_q_sum;
                n_act_n = n_use;
                if (done) begin
                    state_n  = IDLE;
                    count_n  = '0;
                    strobe_n = 1'b1;
                    i_sum_n  = res_i.val;
                    q_sum_n  = res_q.val;
                    sat_n    = res_i.flag | res_q.flag;
                end else begin
                    state_n = ACCUM;
                    count_n = cnt_sum;
                end
            end else if (sync_clr) begin
                state_n = IDLE;
                count_n = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc_i      <= '0;
            acc_q      <= '0;
            count      <= '0;
            n_act      <= '0;
            I_sum      <= '0;
            Q_sum      <= '0;
            strobe_out <= 1'b0;
            sat        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_n;
            acc_i      <= acc_i_n;
            acc_q      <= acc_q_n;
            count      <= count_n;
            n_act      <= n_act_n;
            I_sum      <= i_sum_n;
            Q_sum      <= q_sum_n;
            strobe_out <= strobe_n;
            sat        <= sat_n;
        end
    end

endmodule
